// File: rtl/apb_reg_completer.sv
// APB completer holding a bank of byte-strobed read/write registers behind a base address.
// Fixed wait-state insertion; subError flags out-of-range, unaligned or unprivileged accesses.
module apb_reg_completer #(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter int unsigned          NumRegs    = 4,
  parameter logic [AddrWidth-1:0] BaseAddr   = AddrWidth'(32'h0000_1000),
  parameter int unsigned          WaitCycles = 0,
  parameter bit                   PrivOnly   = 1'b0
) (
  input  logic                           clk,
  input  logic                           nReset,
  input  logic                           sel,
  input  logic                           enable,
  input  logic [AddrWidth-1:0]           addr,
  input  logic                           write,
  input  logic [DataWidth-1:0]           wData,
  input  logic [DataWidth/8-1:0]         strb,
  input  logic [3:0]                     prot,
  output logic                           ready,
  output logic [DataWidth-1:0]           rData,
  output logic                           subError,
  output logic [NumRegs*DataWidth-1:0]   regsOut
);

  localparam int unsigned NumBytes = DataWidth / 8;
  localparam int unsigned OffBits  = $clog2(NumBytes);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                 state_reg;
  logic [3:0]             cnt_reg;
  logic [AddrWidth-1:0]   addr_reg;
  logic                   write_reg;
  logic [DataWidth-1:0]   wdata_reg;
  logic [NumBytes-1:0]    strb_reg;
  logic                   priv_reg;

  logic [AddrWidth-1:0]   off;
  logic [AddrWidth-1:0]   idx;
  logic                   err;
  logic                   ready_int;
  logic                   commit;
  logic [DataWidth-1:0]   rd_sel;
  logic [NumRegs*DataWidth-1:0] regs_flat;

  // Only the privileged bit of prot carries meaning here.
  logic unused_prot;
  assign unused_prot = ^prot[3:1];

  // Decode works purely from the captured setup-phase values.
  assign off = addr_reg - BaseAddr;
  assign idx = off >> OffBits;
  assign err = (addr_reg < BaseAddr)
            || (idx >= AddrWidth'(NumRegs))
            || (off[OffBits-1:0] != '0)
            || (PrivOnly && !priv_reg);

  assign ready_int = (state_reg == ACCESS) && (cnt_reg == 4'd0);
  assign commit    = ready_int && sel && enable && write_reg && !err;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
      strb_reg  <= '0;
      priv_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel && !enable) begin
            addr_reg  <= addr;
            write_reg <= write;
            wdata_reg <= wData;
            strb_reg  <= strb;
            priv_reg  <= prot[0];
            cnt_reg   <= 4'(WaitCycles);
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          if (!sel) begin
            state_reg <= IDLE;
          end else if (enable) begin
            if (cnt_reg != 4'd0) begin
              cnt_reg <= cnt_reg - 4'd1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NumRegs; gi++) begin : g_reg
      logic [DataWidth-1:0] reg_q;

      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          reg_q <= '0;
        end else if (commit && (idx == AddrWidth'(gi))) begin
          for (int b = 0; b < NumBytes; b++) begin
            if (strb_reg[b]) begin
              reg_q[8*b +: 8] <= wdata_reg[8*b +: 8];
            end
          end
        end
      end

      assign regs_flat[gi*DataWidth +: DataWidth] = reg_q;
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (idx == AddrWidth'(i)) begin
        rd_sel = regs_flat[i*DataWidth +: DataWidth];
      end
    end
  end

  assign ready    = ready_int;
  assign subError = ready_int && err;
  assign rData    = (ready_int && !write_reg && !err) ? rd_sel : '0;
  assign regsOut  = regs_flat;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer: a 2-wait-state instance (A) and a
// zero-wait privileged-only instance (B) share one APB bus with separate selects.
module tb_apb_reg_completer;

  logic         clk;
  logic         nreset;
  logic         sel_a, sel_b;
  logic         enable;
  logic [31:0]  addr;
  logic         write;
  logic [31:0]  wdata;
  logic [3:0]   strb;
  logic [3:0]   prot;
  logic         ready_a, ready_b;
  logic [31:0]  rdata_a, rdata_b;
  logic         suberr_a, suberr_b;
  logic [127:0] regs_a, regs_b;

  int n_cmp  = 0;
  int n_fail = 0;

  apb_reg_completer #(
    .AddrWidth(32), .DataWidth(32), .NumRegs(4), .BaseAddr(32'h0000_1000),
    .WaitCycles(2), .PrivOnly(1'b0)
  ) dut_a (
    .clk(clk), .nReset(nreset), .sel(sel_a), .enable(enable), .addr(addr),
    .write(write), .wData(wdata), .strb(strb), .prot(prot),
    .ready(ready_a), .rData(rdata_a), .subError(suberr_a), .regsOut(regs_a)
  );

  apb_reg_completer #(
    .AddrWidth(32), .DataWidth(32), .NumRegs(4), .BaseAddr(32'h0000_1000),
    .WaitCycles(0), .PrivOnly(1'b1)
  ) dut_b (
    .clk(clk), .nReset(nreset), .sel(sel_b), .enable(enable), .addr(addr),
    .write(write), .wData(wdata), .strb(strb), .prot(prot),
    .ready(ready_b), .rData(rdata_b), .subError(suberr_b), .regsOut(regs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus driver: called at posedge+1, returns at posedge+1 after the completing edge.
  // Inputs are scrambled after setup so only captured values can be used.
  task automatic xfer(input bit use_b, input logic [31:0] a, input bit w,
                      input logic [31:0] d, input logic [3:0] s, input logic [3:0] p,
                      input bit idle_after, output logic [31:0] rd, output logic er,
                      output int acc);
    rd = 32'hx; er = 1'bx; acc = 0;
    if (use_b) sel_b = 1'b1; else sel_a = 1'b1;
    enable = 1'b0; addr = a; write = w; wdata = d; strb = s; prot = p;
    @(posedge clk); #1;
    enable = 1'b1; addr = ~a; wdata = ~d; strb = ~s;
    for (int i = 1; i <= 20; i++) begin
      #1;
      if ((use_b ? ready_b : ready_a) === 1'b1) begin
        rd  = use_b ? rdata_b : rdata_a;
        er  = use_b ? suberr_b : suberr_a;
        acc = i;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (idle_after) begin
      sel_a = 1'b0; sel_b = 1'b0; enable = 1'b0;
    end
    $display("xfer dut=%s addr=%h write=%0b data=%h strb=%h prot=%h -> rdata=%h err=%b access_cycles=%0d",
             use_b ? "B" : "A", a, w, d, s, p, rd, er, acc);
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      sel_a = 1'($urandom); sel_b = 1'($urandom); enable = 1'($urandom);
      addr = $urandom; write = 1'($urandom); wdata = $urandom;
      strb = 4'($urandom); prot = 4'($urandom);
      #1;
      n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_a got %b want 0", ready_a); end
      n_cmp++; if (rdata_a !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_a got %h want 0", rdata_a); end
      n_cmp++; if (suberr_a !== 1'b0) begin n_fail++; $display("FAIL reset_suberr_a got %b want 0", suberr_a); end
      n_cmp++; if (regs_a !== 128'h0) begin n_fail++; $display("FAIL reset_regs_a got %h want 0", regs_a); end
      n_cmp++; if (ready_b !== 1'b0 || suberr_b !== 1'b0 || rdata_b !== 32'h0 || regs_b !== 128'h0) begin
        n_fail++; $display("FAIL reset_b got ready=%b err=%b rdata=%h regs=%h want all 0", ready_b, suberr_b, rdata_b, regs_b);
      end
      $display("reset cycle %0d checked", c);
    end
    @(posedge clk); #1;
    nreset = 1'b1; sel_a = 1'b0; sel_b = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wait_write_read();
    logic [31:0] rd; logic er; int acc;
    xfer(1'b0, 32'h1004, 1'b1, 32'hDEADBEEF, 4'hF, 4'h1, 1'b1, rd, er, acc);
    n_cmp++; if (acc !== 3) begin n_fail++; $display("FAIL wait_write_ready_cycle got %0d want 3", acc); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wait_write_err got %b want 0", er); end
    n_cmp++; if (regs_a !== {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}) begin n_fail++; $display("FAIL wait_write_regs got %h want reg1=deadbeef", regs_a); end
    xfer(1'b0, 32'h1004, 1'b0, 32'h0, 4'h0, 4'h1, 1'b1, rd, er, acc);
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wait_read_data got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL wait_read_err got %b want 0", er); end
    n_cmp++; if (acc !== 3) begin n_fail++; $display("FAIL wait_read_ready_cycle got %0d want 3", acc); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int acc;
    xfer(1'b0, 32'h1004, 1'b1, 32'h11223344, 4'b0101, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (regs_a[63:32] !== 32'hDE22BE44) begin n_fail++; $display("FAIL strobe_partial got %h want de22be44", regs_a[63:32]); end
    xfer(1'b0, 32'h1004, 1'b1, 32'hFFFFFFFF, 4'b0000, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL strobe_zero_err got %b want 0", er); end
    n_cmp++; if (regs_a !== {32'h0, 32'h0, 32'hDE22BE44, 32'h0}) begin n_fail++; $display("FAIL strobe_zero_regs got %h want reg1=de22be44", regs_a); end
    xfer(1'b0, 32'h1004, 1'b0, 32'h0, 4'hF, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (rd !== 32'hDE22BE44) begin n_fail++; $display("FAIL strobe_readback got %h want de22be44", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int acc;
    logic [31:0] bad [3];
    bad[0] = 32'h1010; bad[1] = 32'h0FFC; bad[2] = 32'h1002;
    for (int k = 0; k < 3; k++) begin
      xfer(1'b0, bad[k], 1'b1, 32'hCAFEF00D, 4'hF, 4'h1, 1'b1, rd, er, acc);
      n_cmp++; if (er !== 1'b1 || acc !== 3) begin n_fail++; $display("FAIL err_write_%h got err=%b cycle=%0d want err=1 cycle=3", bad[k], er, acc); end
      n_cmp++; if (regs_a !== {32'h0, 32'h0, 32'hDE22BE44, 32'h0}) begin n_fail++; $display("FAIL err_write_regs_%h got %h want unchanged", bad[k], regs_a); end
      xfer(1'b0, bad[k], 1'b0, 32'h0, 4'hF, 4'h1, 1'b1, rd, er, acc);
      n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_read_%h got err=%b rdata=%h want err=1 rdata=0", bad[k], er, rd); end
    end
    xfer(1'b1, 32'h1000, 1'b1, 32'h12345678, 4'hF, 4'h1, 1'b1, rd, er, acc);
    n_cmp++; if (er !== 1'b0 || acc !== 1) begin n_fail++; $display("FAIL priv_ok_write got err=%b cycle=%0d want err=0 cycle=1", er, acc); end
    n_cmp++; if (regs_b[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL priv_ok_reg got %h want 12345678", regs_b[31:0]); end
    xfer(1'b1, 32'h1000, 1'b1, 32'hFFFF0000, 4'hF, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL unpriv_write_err got %b want 1", er); end
    n_cmp++; if (regs_b !== {96'h0, 32'h12345678}) begin n_fail++; $display("FAIL unpriv_write_regs got %h want reg0=12345678", regs_b); end
    xfer(1'b1, 32'h1000, 1'b0, 32'h0, 4'h0, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL unpriv_read got err=%b rdata=%h want err=1 rdata=0", er, rd); end
  endtask

  task automatic test_protocol();
    sel_a = 1'b1; enable = 1'b1; write = 1'b1; addr = 32'h1000; wdata = 32'h99999999; strb = 4'hF;
    #1;
    n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL idle_enable_ready got %b want 0", ready_a); end
    @(posedge clk); #1;
    n_cmp++; if (ready_a !== 1'b0 || regs_a !== {32'h0, 32'h0, 32'hDE22BE44, 32'h0}) begin
      n_fail++; $display("FAIL idle_enable_ignored got ready=%b regs=%h want ready=0 unchanged", ready_a, regs_a);
    end
    sel_a = 1'b0; enable = 1'b0;
    $display("protocol violation in IDLE checked");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int acc;
    xfer(1'b0, 32'h1000, 1'b1, 32'hAAAA5555, 4'hF, 4'h0, 1'b0, rd, er, acc);
    xfer(1'b0, 32'h1008, 1'b1, 32'h0BADCAFE, 4'hF, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (acc !== 3) begin n_fail++; $display("FAIL b2b_second_cycle got %0d want 3", acc); end
    n_cmp++; if (regs_a !== {32'h0, 32'h0BADCAFE, 32'hDE22BE44, 32'hAAAA5555}) begin n_fail++; $display("FAIL b2b_regs got %h want both committed", regs_a); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int acc;
    sel_a = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h100C; wdata = 32'h55AA55AA; strb = 4'hF; prot = 4'h0;
    @(posedge clk); #1;
    enable = 1'b1;
    #1;
    n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL abort_wait_ready got %b want 0", ready_a); end
    @(posedge clk); #1;
    sel_a = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (regs_a[127:96] !== 32'h0) begin n_fail++; $display("FAIL abort_no_write got %h want 0", regs_a[127:96]); end
    $display("abort during wait state checked");
    xfer(1'b0, 32'h100C, 1'b1, 32'h13579BDF, 4'hF, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (acc !== 3 || er !== 1'b0 || regs_a[127:96] !== 32'h13579BDF) begin
      n_fail++; $display("FAIL abort_next_xfer got cycle=%0d err=%b reg3=%h want 3/0/13579bdf", acc, er, regs_a[127:96]);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] rd; logic er; int acc;
    sel_a = 1'b1; enable = 1'b0; write = 1'b1; addr = 32'h1004; wdata = 32'hFFFFFFFF; strb = 4'hF;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    nreset = 1'b0;
    #1;
    n_cmp++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL midreset_ready got %b want 0", ready_a); end
    n_cmp++; if (regs_a !== 128'h0 || regs_b !== 128'h0) begin n_fail++; $display("FAIL midreset_regs got a=%h b=%h want 0", regs_a, regs_b); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (regs_a !== 128'h0) begin n_fail++; $display("FAIL midreset_no_pending got %h want 0", regs_a); end
    nreset = 1'b1; sel_a = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, 32'h1000, 1'b0, 32'h0, 4'h0, 4'h0, 1'b1, rd, er, acc);
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0 || acc !== 3) begin
      n_fail++; $display("FAIL midreset_read got rdata=%h err=%b cycle=%0d want 0/0/3", rd, er, acc);
    end
  endtask

  initial begin
    nreset = 1'b0; sel_a = 1'b0; sel_b = 1'b0; enable = 1'b0;
    addr = '0; write = 1'b0; wdata = '0; strb = '0; prot = '0;
    test_reset();
    test_wait_write_read();
    test_strobes();
    test_errors();
    test_protocol();
    test_back_to_back();
    test_abort();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_reg_completer.md
# apb_reg_completer

APB completer (peripheral end) that serves one selector lane of the single-manager APB bus driven by the team's bridge. It holds a bank of `NumRegs` read/write registers behind a base address and applies byte-strobed writes. It inserts a fixed number of wait states and flags `subError` on illegal accesses. Register contents are exported as a flat vector for the surrounding fabric.

## Interface
- `AddrWidth`, 32, address bit-width
- `DataWidth`, 32, data bit-width; must be a multiple of 8, minimum 16
- `NumRegs`, 4, number of registers, at least 1
- `BaseAddr`, 32'h0000_1000, byte address of register 0; aligned to `DataWidth/8`
- `WaitCycles`, 0, access-phase wait states inserted before `ready` (0–15)
- `PrivOnly`, 0, when 1 any access with `prot[0]`=0 is an error
- `clk`  input  1  clock; all state updates on rising edge
- `nReset`  input  1  reset, asynchronous, active-low
- `sel`  input  1  this peripheral's lane of `selectors`
- `enable`  input  1  access-phase indicator
- `addr`  input  AddrWidth  byte address
- `write`  input  1  1 = write, 0 = read
- `wData`  input  DataWidth  write data
- `strb`  input  DataWidth/8  write byte strobes
- `prot`  input  4  protection attributes; only bit 0 (privileged) is used
- `ready`  output  1  transfer completion
- `rData`  output  DataWidth  read data
- `subError`  output  1  transfer error
- `regsOut`  output  NumRegs*DataWidth  register contents; register i is at bits [i*DataWidth +: DataWidth]

## Operation
- FSM states are IDLE and ACCESS, plus a 4-bit wait counter `cnt`.
- **IDLE**
  - On `sel`=1 && `enable`=0 (setup phase), capture `addr`, `write`, `wData`, `strb` and `prot`.
  - Load `cnt`=`WaitCycles` and go to ACCESS.
  - `sel`&&`enable` seen in IDLE is a protocol violation: ignore it, `ready`=0.
- **ACCESS**
  - Each cycle with `sel`&&`enable` and `cnt`≠0: decrement `cnt`.
  - `ready` = (state==ACCESS && `cnt`==0) is combinational, so `WaitCycles`=0 gives a zero-wait transfer.
  - On the edge where `sel`&&`enable`&&`ready`: commit the write (if legal) and return to IDLE.
  - If `sel` drops in ACCESS before completion: abort to IDLE with no write.
- **Decode** (uses captured values)
  - `off` = `addr` − `BaseAddr`; `idx` = `off` >> log2(`DataWidth/8`).
  - Error if `addr` < `BaseAddr`, or `idx` ≥ `NumRegs`, or the low `off` bits are nonzero (unaligned).
  - Error if `PrivOnly`=1 && `prot[0]`=0.
- **Write**
  - Lane b of register `idx` takes `wData[8b+:8]` where `strb[b]`=1; lanes with `strb[b]`=0 are unchanged.
  - An erroring write changes nothing.
  - `strb`=0 on a legal write is a legal no-op with `subError`=0.
- **Read**
  - `rData` = register `idx` when `ready`&&!`write`&&!error; otherwise 0.
  - `strb` is ignored on reads.
- **Error:** `subError` = `ready` && error; it is 0 whenever `ready`=0.
- **Back-to-back:** a new setup phase in the cycle after completion is accepted normally, with no idle cycle required.

## Timing
- **Reset** (async assert, released synchronously by `clk`): state IDLE, `cnt`=0, all registers 0. Outputs: `ready`=0, `rData`=0, `subError`=0, `regsOut`=0.
- A transfer takes 2+`WaitCycles` cycles: setup cycle, then `WaitCycles` cycles with `ready`=0, then one cycle with `ready`=1.
- Write data is visible on `regsOut` the cycle after the completing edge.
- `ready`, `rData` and `subError` are combinational from registered state and register contents only. They do not depend combinationally on `addr`/`wData`, so captured values are used even if the manager changes inputs mid-access.
- Reset asserted mid-transfer aborts it immediately and discards any pending write.

## Test plan
- **Reset:** hold `nReset`=0 with random inputs → `ready`=0, `rData`=0, `subError`=0, `regsOut`=0.
- **Wait-state write/read** (`WaitCycles`=2): write 0xDEADBEEF to 0x1004 with `strb`=0xF → `ready` high exactly on access cycle 3 and register 1 = 0xDEADBEEF. Then read 0x1004 → `rData`=0xDEADBEEF with `ready`, `subError`=0.
- **Strobes:** register 1 = 0xDEADBEEF, write 0x11223344 with `strb`=0b0101 → register 1 = 0xDE22BE44. Then write with `strb`=0 → unchanged, `subError`=0.
- **Errors:**
  - Address 0x1010 (`NumRegs`=4), 0x0FFC or 0x1002 → `subError`=1 with `ready`, no register change, `rData`=0.
  - With `PrivOnly`=1, `prot`=0 write to 0x1000 → error, register unchanged.
- **Back-to-back and abort:**
  - Two consecutive writes to 0x1000 then 0x1008 with no idle cycle → both committed.
  - `sel` dropped during a wait state → no write, next transfer works.
- **Mid-transfer reset:** assert `nReset` during a wait state of a write → registers 0, `ready`=0. After release, a read of 0x1000 returns 0.
